// File: rtl/lut_mux_seq_if.sv
// lut_mux_seq bus: load port, lookup/sweep requests, output beat, status.
// out_par exists only when LUT_MUX_PARITY_EN is defined.
interface lut_mux_seq_if #(
  parameter int SEL_W = 3,
  parameter int WIDTH = 1
);
  logic             load_valid;
  logic [WIDTH-1:0] load_data;
  logic             load_ready;
  logic             sel_valid;
  logic [SEL_W-1:0] sel;
  logic             sweep_start;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [SEL_W-1:0] out_idx;
  logic             out_last;
  logic             out_err;
  logic             busy;
  logic             table_ok;
`ifdef LUT_MUX_PARITY_EN
  logic             out_par;
`endif

  modport slave (
    input  load_valid, load_data,
    input  sel_valid, sel, sweep_start,
    output load_ready,
    output out_valid, out_data, out_idx,
    output out_last, out_err,
    output busy, table_ok
`ifdef LUT_MUX_PARITY_EN
    , output out_par
`endif
  );

  modport master (
    output load_valid, load_data,
    output sel_valid, sel, sweep_start,
    input  load_ready,
    input  out_valid, out_data, out_idx,
    input  out_last, out_err,
    input  busy, table_ok
`ifdef LUT_MUX_PARITY_EN
    , input out_par
`endif
  );
endinterface

// File: rtl/lut_mux_seq.sv
// Run-time loadable 2^SEL_W x WIDTH lookup table with lookup and sweep reads.
// Ports: clk, rst_n (async low), bus (lut_mux_seq_if.slave); LUT_MUX_PARITY_EN adds out_par.
module lut_mux_seq #(
  parameter int SEL_W = 3,
  parameter int WIDTH = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  lut_mux_seq_if.slave bus
);
  localparam int DEPTH = 1 << SEL_W;
  localparam logic [SEL_W-1:0] LAST = SEL_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SWEEP
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] tab [DEPTH];
  logic [SEL_W-1:0] wr_ptr;
  logic [SEL_W-1:0] sw_ptr;

  logic             beat;
  logic [WIDTH-1:0] b_data;
  logic [SEL_W-1:0] b_idx;
  logic             b_last;
  logic             b_err;

  assign bus.busy       = (state != IDLE);
  assign bus.load_ready = (state != SWEEP);

  // Next output beat; refused beats carry zero data so parity is zero too.
  always_comb begin
    beat   = 1'b0;
    b_data = '0;
    b_idx  = '0;
    b_last = 1'b0;
    b_err  = 1'b0;
    unique case (state)
      IDLE: begin
        if (!bus.load_valid) begin
          if (bus.sweep_start) begin
            beat   = 1'b1;
            b_last = !bus.table_ok;
            b_err  = !bus.table_ok;
            b_data = bus.table_ok ? tab[0] : '0;
          end else if (bus.sel_valid) begin
            beat   = 1'b1;
            b_idx  = bus.sel;
            b_err  = !bus.table_ok;
            b_data = bus.table_ok ? tab[bus.sel] : '0;
          end
        end
      end
      SWEEP: begin
        if (!bus.out_last) begin
          beat   = 1'b1;
          b_idx  = sw_ptr;
          b_last = (sw_ptr == LAST);
          b_data = tab[sw_ptr];
        end else if (bus.sweep_start) begin
          // last beat is on the bus: a back-to-back sweep may start here
          beat   = 1'b1;
          b_data = tab[0];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      sw_ptr       <= '0;
      bus.table_ok <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data <= '0;
      bus.out_idx  <= '0;
      bus.out_last <= 1'b0;
      bus.out_err  <= 1'b0;
`ifdef LUT_MUX_PARITY_EN
      bus.out_par  <= 1'b0;
`endif
      for (int i = 0; i < DEPTH; i++) begin
        tab[i] <= '0;
      end
    end else begin
      bus.out_valid <= beat;
      bus.out_last  <= b_last;
      bus.out_err   <= b_err;
      if (beat) begin
        bus.out_data <= b_data;
        bus.out_idx  <= b_idx;
`ifdef LUT_MUX_PARITY_EN
        bus.out_par  <= ^b_data;
`endif
      end
      unique case (state)
        IDLE: begin
          if (bus.load_valid) begin
            tab[wr_ptr]  <= bus.load_data;
            wr_ptr       <= wr_ptr + 1'b1;
            bus.table_ok <= 1'b0;
            state        <= LOAD;
          end else if (bus.sweep_start && bus.table_ok) begin
            sw_ptr <= SEL_W'(1);
            state  <= SWEEP;
          end
        end
        LOAD: begin
          if (bus.load_valid) begin
            tab[wr_ptr] <= bus.load_data;
            wr_ptr      <= wr_ptr + 1'b1;
            if (wr_ptr == LAST) begin
              bus.table_ok <= 1'b1;
              state        <= IDLE;
            end
          end
        end
        SWEEP: begin
          if (!bus.out_last) begin
            sw_ptr <= sw_ptr + 1'b1;
          end else if (bus.sweep_start) begin
            sw_ptr <= SEL_W'(1);
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lut_mux_seq.sv
// Scoreboard bench for lut_mux_seq: random loads, lookups and sweeps.
// Define LUT_MUX_PARITY_EN to run with WIDTH=4 and check out_par.
module tb_lut_mux_seq;
  localparam int SEL_W = 3;
`ifdef LUT_MUX_PARITY_EN
  localparam int W = 4;
`else
  localparam int W = 1;
`endif
  localparam int D = 1 << SEL_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lut_mux_seq_if #(.SEL_W(SEL_W), .WIDTH(W)) bus ();

  lut_mux_seq #(.SEL_W(SEL_W), .WIDTH(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    logic [W-1:0] data;
    int           idx;
    bit           last;
    bit           err;
    int           cyc;
  } exp_t;

  exp_t         q [$];
  int           checks = 0;
  int           failures = 0;
  int           cyc = 0;
  logic [W-1:0] mtab [D];
  bit           mok;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, a, e, cyc);
    end
  endtask

  task automatic push(input logic [W-1:0] d, input int idx,
                      input bit last, input bit err, input int c);
    exp_t e;
    e.data = d;
    e.idx  = idx;
    e.last = last;
    e.err  = err;
    e.cyc  = c;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat: got idx %0d expected no beat", bus.out_idx);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("out_data", int'(bus.out_data), int'(e.data));
          chk("out_idx", int'(bus.out_idx), e.idx);
          chk("out_last", int'(bus.out_last), int'(e.last));
          chk("out_err", int'(bus.out_err), int'(e.err));
          chk("beat_cycle", cyc, e.cyc);
`ifdef LUT_MUX_PARITY_EN
          chk("out_par", int'(bus.out_par), e.err ? 0 : int'(^e.data));
`endif
        end
      end else begin
        chk("idle_pulses", int'(bus.out_last | bus.out_err), 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.load_valid  = 1'b0;
    bus.sel_valid   = 1'b0;
    bus.sweep_start = 1'b0;
  endtask

  task automatic do_lookup(input int s);
    bus.sel_valid = 1'b1;
    bus.sel = SEL_W'(s);
    push(mok ? mtab[s] : '0, s, 1'b0, !mok, cyc + 1);
    tick();
    clr();
    chk("busy_lookup", int'(bus.busy), 0);
  endtask

  task automatic push_sweep(input int base);
    for (int k = 0; k < D; k++)
      push(mtab[k], k, k == D - 1, 1'b0, base + 1 + k);
  endtask

  task automatic do_sweep(input int n, input bit noise);
    bus.sweep_start = 1'b1;
    if (mok) push_sweep(cyc);
    else push('0, 0, 1'b1, 1'b1, cyc + 1);
    tick();
    clr();
    if (mok) begin
      for (int r = 0; r < n; r++) begin
        for (int k = 0; k < D; k++) begin
          chk("busy_sweep", int'(bus.busy), 1);
          chk("load_ready_sweep", int'(bus.load_ready), 0);
          if (noise) begin
            bus.sel_valid  = 1'($urandom);
            bus.sel        = SEL_W'($urandom);
            bus.load_valid = 1'($urandom);
            bus.load_data  = W'($urandom);
          end
          if (k == D - 1 && r < n - 1) begin
            bus.sweep_start = 1'b1;
            push_sweep(cyc);
          end
          tick();
          clr();
        end
      end
    end
    chk("busy_after_sweep", int'(bus.busy), 0);
  endtask

  task automatic do_load(input logic [W-1:0] v [D], input bit gaps, input bit prio);
    for (int i = 0; i < D; i++) begin
      if (gaps && i > 0) begin
        repeat ($urandom_range(0, 2)) begin
          bus.sel_valid   = 1'($urandom);
          bus.sel         = SEL_W'($urandom);
          bus.sweep_start = 1'($urandom);
          chk("load_ready_gap", int'(bus.load_ready), 1);
          tick();
          clr();
        end
      end
      bus.load_valid = 1'b1;
      bus.load_data  = v[i];
      if (i == 0 && prio) begin
        bus.sel_valid   = 1'b1;
        bus.sel         = SEL_W'($urandom);
        bus.sweep_start = 1'b1;
      end
      chk("load_ready", int'(bus.load_ready), 1);
      tick();
      clr();
      if (i < D - 1) chk("table_ok_loading", int'(bus.table_ok), 0);
    end
    for (int i = 0; i < D; i++) mtab[i] = v[i];
    mok = 1'b1;
    chk("table_ok_loaded", int'(bus.table_ok), 1);
    chk("busy_loaded", int'(bus.busy), 0);
  endtask

  task automatic reset_checks();
    chk("rst_table_ok", int'(bus.table_ok), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_load_ready", int'(bus.load_ready), 1);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_data", int'(bus.out_data), 0);
    chk("rst_out_idx", int'(bus.out_idx), 0);
    chk("rst_out_last", int'(bus.out_last), 0);
    chk("rst_out_err", int'(bus.out_err), 0);
`ifdef LUT_MUX_PARITY_EN
    chk("rst_out_par", int'(bus.out_par), 0);
`endif
  endtask

  task automatic partial_then_reset(input int n);
    for (int i = 0; i < n; i++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = W'($urandom);
      tick();
      clr();
    end
    #2 rst_n = 1'b0;
    #1 reset_checks();
    for (int i = 0; i < D; i++) mtab[i] = '0;
    mok = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  logic [W-1:0] v [D];
  logic [7:0]   pat;

  initial begin
    clr();
    bus.sel = '0;
    bus.load_data = '0;
    for (int i = 0; i < D; i++) mtab[i] = '0;
    mok = 1'b0;
    #12 reset_checks();
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    do_lookup(5);
    do_sweep(1, 1'b0);
    tick();

    pat = 8'b1001_0110;
    for (int i = 0; i < D; i++) v[i] = W'(pat[i]);
    do_load(v, 1'b0, 1'b1);
    do_lookup(3);
    do_lookup(7);
    do_sweep(1, 1'b1);
    do_sweep(2, 1'b0);

    partial_then_reset(4);
    do_lookup(2);
    pat = 8'b0111_0001;
    for (int i = 0; i < D; i++) v[i] = W'(pat[i]);
    do_load(v, 1'b1, 1'b0);
    do_lookup(4);
    do_lookup(3);

`ifdef LUT_MUX_PARITY_EN
    for (int i = 0; i < D; i++) v[i] = W'($urandom);
    v[0] = 4'b1011;
    v[1] = 4'b1001;
    do_load(v, 1'b0, 1'b0);
    do_lookup(0);
    do_lookup(1);
`endif

    repeat (6) begin
      for (int i = 0; i < D; i++) v[i] = W'($urandom);
      do_load(v, 1'b1, 1'($urandom));
      repeat (10) begin
        case ($urandom_range(0, 3))
          0: do_lookup($urandom_range(0, D - 1));
          1: tick();
          2: do_sweep($urandom_range(1, 2), 1'b1);
          default: do_lookup($urandom_range(0, D - 1));
        endcase
      end
    end

    for (int t = 0; t < 50 && q.size() != 0; t++) tick();
    tick();
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: got %0d pending beats expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
